// File: rtl/bictr_sweep_ctrl_pkg.sv
// rtl/bictr_sweep_ctrl_pkg.sv - shared types and constants for the counter sweep controller
//
// Contents:
//   sweep_state_t : controller state encoding (IDLE, LOAD, UP, DOWN, DONE)
//   LOAD_ACTIVE   : asserted level of the counter's active-low load input
package bictr_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_DONE = 3'd4
    } sweep_state_t;

    localparam logic LOAD_ACTIVE = 1'b0;

endpackage

// File: rtl/bictr_window_chk.sv
// rtl/bictr_window_chk.sv - combinational lo <= count <= hi window check
//
// Ports:
//   count         in  WIDTH  value under test
//   lo            in  WIDTH  inclusive lower bound
//   hi            in  WIDTH  inclusive upper bound
//   out_of_window out  1     high when count < lo or count > hi (unsigned)
module bictr_window_chk #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic             out_of_window
);

    assign out_of_window = (count < lo) || (count > hi);

endmodule

// File: rtl/bictr_sweep_ctrl.sv
// rtl/bictr_sweep_ctrl.sv - drives an up/down counter through lo->hi->lo sweeps
//
// Ports:
//   clk, reset        clock and synchronous active-low reset
//   start/abort/halt  sequencer controls
//   lo/hi/sweeps      sweep window and repeat count, captured on accepted start
//   count/tercnt      feedback from the attached counter
//   data/up_dn/load/cen/count_to  counter controls (load is active-low)
//   busy/done/err     status; done and err are one-cycle pulses
//   sweep_cnt         completed sweeps, held until the next accepted start
module bictr_sweep_ctrl
    import bictr_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SWEEPW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              halt,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [SWEEPW-1:0] sweeps,
    input  logic [WIDTH-1:0]  count,
    input  logic              tercnt,
    output logic [WIDTH-1:0]  data,
    output logic              up_dn,
    output logic              load,
    output logic              cen,
    output logic [WIDTH-1:0]  count_to,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SWEEPW-1:0] sweep_cnt
);

    sweep_state_t      state;
    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  hi_q;
    logic [SWEEPW-1:0] sweeps_q;
    logic [SWEEPW-1:0] sweep_cnt_q;
    logic              err_q;
    logic              out_of_window;
    logic [SWEEPW-1:0] sweep_inc;

    bictr_window_chk #(
        .WIDTH(WIDTH)
    ) u_window_chk (
        .count         (count),
        .lo            (lo_q),
        .hi            (hi_q),
        .out_of_window (out_of_window)
    );

    assign sweep_inc = sweep_cnt_q + SWEEPW'(1);

    // Priority inside UP/DOWN: abort, then window error, then tercnt.
    // halt only affects cen, so it needs no branch here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            sweeps_q    <= '0;
            sweep_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if ((lo >= hi) || (sweeps == '0)) begin
                            err_q <= 1'b1;
                        end else begin
                            lo_q        <= lo;
                            hi_q        <= hi;
                            sweeps_q    <= sweeps;
                            sweep_cnt_q <= '0;
                            state       <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    state <= abort ? ST_IDLE : ST_UP;
                end
                ST_UP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (out_of_window) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else if (tercnt) begin
                        state <= ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (out_of_window) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else if (tercnt) begin
                        sweep_cnt_q <= sweep_inc;
                        state       <= (sweep_inc == sweeps_q) ? ST_DONE : ST_UP;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Counter controls are decoded straight from state so the counter sees
    // them in the same cycle; cen drops on tercnt to give the one-cycle
    // dwell at each end of the window.
    always_comb begin
        data     = '0;
        up_dn    = 1'b1;
        load     = ~LOAD_ACTIVE;
        cen      = 1'b0;
        count_to = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_LOAD: begin
                load = LOAD_ACTIVE;
                data = lo_q;
                busy = 1'b1;
            end
            ST_UP: begin
                count_to = hi_q;
                cen      = ~halt & ~tercnt;
                busy     = 1'b1;
            end
            ST_DOWN: begin
                up_dn    = 1'b0;
                count_to = lo_q;
                cen      = ~halt & ~tercnt;
                busy     = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign err       = err_q;
    assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_bictr_sweep_ctrl.sv
// tb/tb_bictr_sweep_ctrl.sv - bench for bictr_sweep_ctrl closing the loop through a counter model
module tb_bictr_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       halt = 1'b0;
    logic [3:0] lo = '0;
    logic [3:0] hi = '0;
    logic [3:0] sweeps = '0;
    logic [3:0] count;
    logic       tercnt;
    logic [3:0] data;
    logic       up_dn;
    logic       load;
    logic       cen;
    logic [3:0] count_to;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] sweep_cnt;

    logic       force_en = 1'b0;
    logic [3:0] force_val = '0;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bictr_sweep_ctrl #(.WIDTH(4), .SWEEPW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .halt      (halt),
        .lo        (lo),
        .hi        (hi),
        .sweeps    (sweeps),
        .count     (count),
        .tercnt    (tercnt),
        .data      (data),
        .up_dn     (up_dn),
        .load      (load),
        .cen       (cen),
        .count_to  (count_to),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sweep_cnt (sweep_cnt)
    );

    // Up/down counter with active-low load and dynamic count-to flag.
    always_ff @(posedge clk) begin
        if (!reset)        count <= '0;
        else if (force_en) count <= force_val;
        else if (!load)    count <= data;
        else if (cen)      count <= up_dn ? count + 4'd1 : count - 4'd1;
    end
    assign tercnt = (count == count_to);

    // {data,up_dn,load,cen,count_to,busy,done,err,sweep_cnt} at reset/idle
    localparam logic [18:0] IDLE_VEC = {4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({data, up_dn, load, cen, count_to, busy, done, err, sweep_cnt} !== IDLE_VEC)
            $display("FAIL reset_outputs: got %h expected %h",
                     {data, up_dn, load, cen, count_to, busy, done, err, sweep_cnt}, IDLE_VEC);
        else n_pass++;
    endtask

    // Full sweep run; expected counts, sweep checkpoints and the done cycle
    // are pushed before stimulus and popped as the DUT produces them.
    task automatic run_sweep(input string name, input logic [3:0] l, input logic [3:0] h,
                             input logic [3:0] s, input int h0, input int h1);
        logic [3:0] exp_q[$];
        int         cp_cyc[$];
        int         cp_val[$];
        logic [3:0] v;
        logic [3:0] e;
        int         per_sweep, nh, exp_done, ph, sw, c;
        bit         seen_done, seen_err;
        per_sweep = 2 * (int'(h) - int'(l) + 1);
        nh        = (h1 >= h0) ? (h1 - h0 + 1) : 0;
        exp_done  = 2 + int'(s) * per_sweep + nh;
        v = l; ph = 0; sw = 0; c = 2;
        while (1) begin
            exp_q.push_back(v);
            if (ph == 0) begin
                if (v == h) ph = 1;
                else if (!(c >= h0 && c <= h1)) v = v + 4'd1;
            end else begin
                if (v == l) begin
                    sw++;
                    if (sw == int'(s)) break;
                    ph = 0;
                end else if (!(c >= h0 && c <= h1)) v = v - 4'd1;
            end
            c++;
        end
        for (int k = 1; k <= int'(s); k++) begin
            cp_cyc.push_back(2 + k * per_sweep + nh);
            cp_val.push_back(k);
        end
        seen_done = 0; seen_err = 0;
        @(negedge clk);
        lo = l; hi = h; sweeps = s; start = 1'b1;
        for (int cy = 1; cy <= exp_done + 3; cy++) begin
            @(negedge clk);
            start = 1'b0;
            halt = (cy >= h0 && cy <= h1);
            #1;
            if (cy == 1) begin
                n_checks++;
                if (load !== 1'b0 || data !== l)
                    $display("FAIL %s_load: got load=%b data=%0d expected load=0 data=%0d", name, load, data, l);
                else n_pass++;
            end
            if (busy && load) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL %s_extra_count: got count=%0d at c%0d expected no more counting", name, count, cy);
                else begin
                    e = exp_q.pop_front();
                    if (count !== e) $display("FAIL %s_count_c%0d: got %0d expected %0d", name, cy, count, e);
                    else n_pass++;
                end
            end
            if (cp_cyc.size() != 0 && cp_cyc[0] == cy) begin
                n_checks++;
                void'(cp_cyc.pop_front());
                if (int'(sweep_cnt) !== cp_val[0])
                    $display("FAIL %s_sweep_cnt_c%0d: got %0d expected %0d", name, cy, sweep_cnt, cp_val[0]);
                else n_pass++;
                void'(cp_val.pop_front());
            end
            if (done) begin
                seen_done = 1;
                n_checks++;
                if (cy !== exp_done) $display("FAIL %s_done_cycle: got c%0d expected c%0d", name, cy, exp_done);
                else n_pass++;
            end
            if (err) seen_err = 1;
        end
        halt = 1'b0;
        n_checks++;
        if (!seen_done || seen_err || exp_q.size() != 0)
            $display("FAIL %s_end: got done_seen=%0d err_seen=%0d left=%0d expected 1 0 0",
                     name, seen_done, seen_err, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_bad_start(input string name, input logic [3:0] l, input logic [3:0] h,
                                  input logic [3:0] s, input logic ab, input logic exp_err);
        bit seen_load;
        seen_load = 0;
        @(negedge clk);
        lo = l; hi = h; sweeps = s; start = 1'b1; abort = ab;
        #1;
        if (!load) seen_load = 1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        if (!load) seen_load = 1;
        n_checks++;
        if (err !== exp_err || busy !== 1'b0)
            $display("FAIL %s_c1: got err=%b busy=%b expected err=%b busy=0", name, err, busy, exp_err);
        else n_pass++;
        @(negedge clk);
        #1;
        if (!load) seen_load = 1;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0 || seen_load)
            $display("FAIL %s_c2: got err=%b busy=%b load_pulse=%0d expected 0 0 0", name, err, busy, seen_load);
        else n_pass++;
    endtask

    task automatic test_window_err();
        bit seen_done;
        seen_done = 0;
        @(negedge clk);
        lo = 4'd2; hi = 4'd5; sweeps = 4'd1; start = 1'b1;
        for (int cy = 1; cy <= 12; cy++) begin
            @(negedge clk);
            start = 1'b0;
            force_val = 4'd7;
            force_en = (cy == 3);
            #1;
            if (done) seen_done = 1;
            if (cy == 4) begin
                n_checks++;
                if (err !== 1'b0 || busy !== 1'b1)
                    $display("FAIL win_c4: got err=%b busy=%b expected err=0 busy=1", err, busy);
                else n_pass++;
            end
            if (cy == 5) begin
                n_checks++;
                if (err !== 1'b1 || busy !== 1'b0 || load !== 1'b1 || cen !== 1'b0)
                    $display("FAIL win_c5: got err=%b busy=%b load=%b cen=%b expected 1 0 1 0", err, busy, load, cen);
                else n_pass++;
            end
            if (cy == 6) begin
                n_checks++;
                if (err !== 1'b0) $display("FAIL win_err_pulse: got err=%b at c6 expected 0", err);
                else n_pass++;
            end
        end
        force_en = 1'b0;
        n_checks++;
        if (seen_done) $display("FAIL win_no_done: got done=1 expected done never");
        else n_pass++;
    endtask

    task automatic test_abort();
        bit seen_done;
        seen_done = 0;
        @(negedge clk);
        lo = 4'd2; hi = 4'd5; sweeps = 4'd1; start = 1'b1;
        for (int cy = 1; cy <= 12; cy++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (cy == 6);
            #1;
            if (done) seen_done = 1;
            if (cy == 6) begin
                n_checks++;
                if (busy !== 1'b1 || up_dn !== 1'b0)
                    $display("FAIL abort_c6: got busy=%b up_dn=%b expected busy=1 up_dn=0", busy, up_dn);
                else n_pass++;
            end
            if (cy == 7) begin
                n_checks++;
                if (busy !== 1'b0 || err !== 1'b0 || cen !== 1'b0 || load !== 1'b1)
                    $display("FAIL abort_c7: got busy=%b err=%b cen=%b load=%b expected 0 0 0 1", busy, err, cen, load);
                else n_pass++;
            end
        end
        n_checks++;
        if (seen_done) $display("FAIL abort_no_done: got done=1 expected done never");
        else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge clk);
        lo = 4'd2; hi = 4'd5; sweeps = 4'd2; start = 1'b1;
        for (int cy = 1; cy <= 6; cy++) begin
            @(negedge clk);
            start = 1'b0;
            if (cy == 5) reset = 1'b0;
            #1;
        end
        n_checks++;
        if ({data, up_dn, load, cen, count_to, busy, done, err, sweep_cnt} !== IDLE_VEC)
            $display("FAIL reset_mid_sweep: got %h expected %h",
                     {data, up_dn, load, cen, count_to, busy, done, err, sweep_cnt}, IDLE_VEC);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_release: got busy=%b done=%b err=%b expected 0 0 0", busy, done, err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        run_sweep("sweep1", 4'd2, 4'd5, 4'd1, 1, 0);
        run_sweep("sweep2", 4'd2, 4'd5, 4'd2, 1, 0);
        run_sweep("halt", 4'd2, 4'd5, 4'd1, 3, 4);
        run_sweep("wide", 4'd0, 4'd15, 4'd1, 1, 0);
        test_bad_start("lo_eq_hi", 4'd5, 4'd5, 4'd1, 1'b0, 1'b1);
        test_bad_start("zero_sweeps", 4'd2, 4'd5, 4'd0, 1'b0, 1'b1);
        test_bad_start("start_abort", 4'd2, 4'd5, 4'd1, 1'b1, 1'b0);
        test_window_err();
        test_abort();
        test_reset_mid_sweep();
        run_sweep("after_reset", 4'd1, 4'd3, 4'd3, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bictr_sweep_ctrl.md
# bictr_sweep_ctrl

Sweep controller that drives an up/down binary counter with dynamic count-to flag (data/up_dn/load/cen/count_to in, count/tercnt out) from the initiator side. On a start request it loads a lower bound, counts up to an upper bound, reverses, and counts back down. It repeats for a programmed number of sweeps and reports done, while checking that the counter stays inside the window. It sits between a register-programmed test/scan sequencer and the counter instance.

## Interface
- WIDTH, 4, counter width; must equal the attached counter's width
- SWEEPW, 4, width of sweep count and sweep progress
- clk  in  1  rising-edge clock, shared with the counter
- reset  in  1  reset reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- abort  in  1  return to IDLE next cycle, no done
- halt  in  1  pause counting (cen forced 0) in UP/DOWN
- lo  in  WIDTH  lower bound, captured on accepted start
- hi  in  WIDTH  upper bound, captured on accepted start
- sweeps  in  SWEEPW  number of up+down sweeps, captured on start
- count  in  WIDTH  counter value
- tercnt  in  1  counter flag, count == count_to
- data  out  WIDTH  counter load value
- up_dn  out  1  1 = up, 0 = down
- load  out  1  active-low counter load
- cen  out  1  counter enable
- count_to  out  WIDTH  counter compare value
- busy  out  1  high in LOAD/UP/DOWN
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse
- sweep_cnt  out  SWEEPW  completed sweeps

## Operation
- States: IDLE, LOAD, UP, DOWN, DONE. lo_q, hi_q and sweeps_q are registers captured on an accepted start.
- IDLE: load=1, cen=0, up_dn=1, data=0, count_to=0. On start, if lo>=hi or sweeps==0: err pulse, stay IDLE. Otherwise capture the inputs, clear sweep_cnt, go to LOAD.
- LOAD (1 cycle): load=0, data=lo_q, cen=0. Next state UP.
- UP: up_dn=1, count_to=hi_q, cen=~halt & ~tercnt. If tercnt, go to DOWN. The counter dwells one cycle at hi.
- DOWN: up_dn=0, count_to=lo_q, cen=~halt & ~tercnt. If tercnt, increment sweep_cnt. If the incremented value equals sweeps_q, go to DONE; otherwise go to UP. The counter dwells one cycle at lo.
- DONE (1 cycle): done=1. Next state IDLE. sweep_cnt holds until the next accepted start.
- Window check in UP/DOWN: if count<lo_q or count>hi_q, pulse err and go to IDLE.
- Priority: abort > window error > tercnt > halt.
- In IDLE, start is ignored if abort is also high. In all other states, start is ignored.
- All comparisons are unsigned. sweep_cnt wraps modulo 2^SWEEPW; it cannot wrap before DONE because sweeps_q is at most 2^SWEEPW-1.

## Timing
- Reset, and the first cycle after reset release: state IDLE, data=0, up_dn=1, load=1, cen=0, count_to=0, busy=0, done=0, err=0, sweep_cnt=0. Registered state is cleared in the same way.
- Reset asserted mid-sweep: IDLE on the next edge, with no done or err pulse.
- data/up_dn/load/cen/count_to/busy/done are combinational from state, the captured registers and tercnt.
- err is registered: it is high in the cycle after the faulty sample.
- Start sampled at cycle 0: LOAD at cycle 1, UP at cycle 2 with count=lo.
- Each sweep takes 2*(hi-lo+1) cycles. done is high at cycle 2 + sweeps*2*(hi-lo+1), plus one cycle per halted UP/DOWN cycle.
- abort sampled at cycle n: IDLE at cycle n+1.

## Structure
- Shared package: state enum (IDLE, LOAD, UP, DOWN, DONE) and the LOAD_ACTIVE=1'b0 constant.
- One sub-module: bictr_window_chk, a combinational lo<=count<=hi check that produces the out-of-window flag.
- The bench instantiates the existing counter and closes the loop.

## Test plan
- lo=2, hi=5, sweeps=1, start at c0: count 2,3,4,5,5,4,3,2; done at c10; sweep_cnt=1; err never high.
- lo=2, hi=5, sweeps=2: done at c18; sweep_cnt reads 1 at c10 and 2 at c18.
- Same as the first case with halt high at c3-c4: count holds at 3 for two extra cycles; done at c12.
- start with lo=5, hi=5, and separately with sweeps=0: err high on the next cycle, busy stays 0, no load pulse.
- Force the counter to 7 at c4, with lo=2 and hi=5: err high at c5, state IDLE at c5, no done.
- abort at c6, then reset low mid-sweep in a second run: IDLE next cycle, done=0, all outputs at their reset values.
